dm_bus_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters:
  - master 0 (M0): the CPU M-stage data port;
  - master 1 (M1): a DMA/peripheral copy engine.
- Grants at most one access per cycle and drives the memory port. Returns read data one cycle later to the owning master.
- M0 has default priority. A starvation counter and a bounded M1 lock guarantee M1 forward progress.
- Sits between the CPU Mem_* port and the DM/bridge.

---
 rtl/dm_bus_arbiter.sv | 77 +++++++
 tb/tb_dm_bus_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_bus_arbiter.sv
// dm_bus_arbiter: two-master data-memory arbiter, M0 priority with M1 starvation guard and bounded lock
module dm_bus_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int LOCK_MAX   = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_stall_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_lock_i,
  input  logic [31:0] m1_addr_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        s_en_o,
  output logic [31:0] s_addr_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_wdata_o,
  input  logic [31:0] s_rdata_i
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;
  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d, lock_q, lock_d;
  logic        held_q, pend0_q, pend1_q;
  logic [31:0] rd0_q, rd1_q;
  logic        lock_win, g0, g1;
  always_comb begin
    lock_win = state_q == OWN1 && held_q && m1_req_i && lock_q < 4'(LOCK_MAX);
    g1       = lock_win || (m1_req_i && starve_q >= 4'(STARVE_MAX)) || (m1_req_i && !m0_req_i);
    g0       = m0_req_i && !g1;
    state_d  = g1 ? OWN1 : g0 ? OWN0 : IDLE;
    starve_d = (g0 && m1_req_i) ? (starve_q == 4'd15 ? starve_q : starve_q + 4'd1) : 4'd0;
    lock_d   = g1 ? (lock_win ? lock_q + 4'd1 : 4'd1) : 4'd0;
  end
  assign m0_gnt_o    = g0;
  assign m1_gnt_o    = g1;
  assign m0_stall_o  = m0_req_i && !g0;
  assign s_en_o      = g0 || g1;
  assign s_addr_o    = g1 ? {m1_addr_i[31:2], 2'b00} : g0 ? {m0_addr_i[31:2], 2'b00} : 32'd0;
  assign s_be_o      = g1 ? m1_be_i : g0 ? m0_be_i : 4'd0;
  assign s_wdata_o   = g1 ? m1_wdata_i : g0 ? m0_wdata_i : 32'd0;
  assign m0_rvalid_o = pend0_q;
  assign m1_rvalid_o = pend1_q;
  // Read data passes straight through in the return cycle and is held afterwards
  assign m0_rdata_o  = pend0_q ? s_rdata_i : rd0_q;
  assign m1_rdata_o  = pend1_q ? s_rdata_i : rd1_q;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      starve_q <= 4'd0;
      lock_q   <= 4'd0;
      held_q   <= 1'b0;
      pend0_q  <= 1'b0;
      pend1_q  <= 1'b0;
      rd0_q    <= 32'd0;
      rd1_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      lock_q   <= lock_d;
      held_q   <= g1 && m1_lock_i;
      pend0_q  <= g0 && m0_be_i == 4'd0;
      pend1_q  <= g1 && m1_be_i == 4'd0;
      if (pend0_q) rd0_q <= s_rdata_i;
      if (pend1_q) rd1_q <= s_rdata_i;
    end
  end
endmodule

// File: tb/tb_dm_bus_arbiter.sv
// tb_dm_bus_arbiter: directed and randomized checks of dm_bus_arbiter against a rule-level model
module tb_dm_bus_arbiter;
  localparam int STARVE = 4;
  localparam int LOCKN  = 8;
  logic        clk = 0, reset = 1;
  logic        m0_req = 0, m1_req = 0, m1_lock = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0, s_rdata = 0;
  logic [3:0]  m0_be = 0, m1_be = 0;
  logic        m0_gnt, m0_stall, m0_rvalid, m1_gnt, m1_rvalid, s_en;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [3:0]  s_be;
  int checks = 0, errors = 0;
  int last, starve, lockc, pend;
  bit held, e_r1, e_rv0, e_rv1;
  logic [31:0] r0, r1, e_rd0, e_rd1;
  int e_g;

  dm_bus_arbiter #(.STARVE_MAX(STARVE), .LOCK_MAX(LOCKN)) dut (
    .clk_i(clk), .reset_i(reset),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_be_i(m0_be), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(m0_gnt), .m0_stall_o(m0_stall), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_lock_i(m1_lock), .m1_addr_i(m1_addr), .m1_be_i(m1_be), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .s_en_o(s_en), .s_addr_o(s_addr), .s_be_o(s_be), .s_wdata_o(s_wdata), .s_rdata_i(s_rdata)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    last = 0; starve = 0; lockc = 0; held = 0; pend = 0; r0 = 0; r1 = 0;
  endtask

  task automatic drive(input bit q0, input logic [31:0] a0, input logic [3:0] b0, input logic [31:0] w0,
                       input bit q1, input bit lk, input logic [31:0] a1, input logic [3:0] b1,
                       input logic [31:0] w1, input logic [31:0] sr);
    @(negedge clk);
    m0_req = q0; m0_addr = a0; m0_be = b0; m0_wdata = w0;
    m1_req = q1; m1_lock = lk; m1_addr = a1; m1_be = b1; m1_wdata = w1; s_rdata = sr;
    #1;
    e_r1 = last == 2 && held && q1 && lockc < LOCKN;
    e_g  = e_r1 ? 2 : (q1 && starve >= STARVE) ? 2 : q0 ? 1 : q1 ? 2 : 0;
    e_rv0 = pend == 1;
    e_rv1 = pend == 2;
    e_rd0 = e_rv0 ? sr : r0;
    e_rd1 = e_rv1 ? sr : r1;
  endtask

  task automatic tick();
    @(posedge clk);
    starve = (e_g == 1 && m1_req) ? (starve < 15 ? starve + 1 : 15) : 0;
    lockc  = e_g == 2 ? (e_r1 ? lockc + 1 : 1) : 0;
    held   = e_g == 2 && m1_lock;
    last   = e_g;
    pend   = (e_g == 1 && m0_be == 0) ? 1 : (e_g == 2 && m1_be == 0) ? 2 : 0;
    r0 = e_rd0; r1 = e_rd1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset();
    model_reset();
    @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt, s_en, m0_rvalid, m1_rvalid, m0_stall} !== 6'd0 || s_addr !== 0 || s_be !== 0 ||
        s_wdata !== 0 || m0_rdata !== 0 || m1_rdata !== 0) begin
      errors++;
      $display("FAIL reset_outputs gnt=%b%b en=%b rv=%b%b addr=%h rd0=%h rd1=%h", m0_gnt, m1_gnt, s_en,
               m0_rvalid, m1_rvalid, s_addr, m0_rdata, m1_rdata);
    end
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_m0_read();
    drive(1, 32'h0000_1004, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (m0_gnt !== 1 || m1_gnt !== 0 || s_en !== 1 || s_addr !== 32'h0000_1004 || s_be !== 0) begin
      errors++;
      $display("FAIL m0_read_grant gnt=%b%b en=%b addr=%h be=%h need 10 1 00001004 0", m0_gnt, m1_gnt, s_en, s_addr, s_be);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF);
    checks++;
    if (m0_rvalid !== 1 || m0_rdata !== 32'hDEAD_BEEF || m1_rvalid !== 0) begin
      errors++;
      $display("FAIL m0_read_return rv0=%b rd0=%h rv1=%b need 1 deadbeef 0", m0_rvalid, m0_rdata, m1_rvalid);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1111_2222);
    checks++;
    if (m0_rvalid !== 0 || m0_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL m0_rdata_hold rv0=%b rd0=%h need 0 deadbeef", m0_rvalid, m0_rdata);
    end
    tick();
  endtask

  task automatic test_starve();
    idle();
    for (int i = 0; i < 15; i++) begin
      bit want1;
      want1 = (i % 5) == 4;
      drive(1, 32'h100 + i, 4'hF, i, 1, 0, 32'h200 + i, 4'hF, i, 0);
      checks++;
      if (m1_gnt !== want1 || m0_gnt !== !want1 || m0_stall !== want1 || e_g != (want1 ? 2 : 1)) begin
        errors++;
        $display("FAIL starve_pattern cyc=%0d gnt=%b%b stall=%b model=%0d need m1=%b", i, m0_gnt, m1_gnt, m0_stall, e_g, want1);
      end
      tick();
    end
  endtask

  task automatic test_lock();
    idle();
    for (int i = 0; i < 9; i++) begin
      bit want1;
      want1 = i < LOCKN;
      drive(i != 0, 32'h40, 4'hF, 0, 1, 1, 32'h80, 4'hF, 0, 0);
      checks++;
      if (m1_gnt !== want1 || m0_gnt !== !want1 || s_addr !== (want1 ? 32'h80 : 32'h40)) begin
        errors++;
        $display("FAIL lock_run cyc=%0d gnt=%b%b addr=%h need m1=%b", i, m0_gnt, m1_gnt, s_addr, want1);
      end
      tick();
    end
    drive(1, 32'h40, 4'hF, 0, 1, 1, 32'h80, 4'hF, 0, 0);
    checks++;
    if (m0_gnt !== 1 || m1_gnt !== 0) begin
      errors++;
      $display("FAIL lock_ignored gnt=%b%b need 10", m0_gnt, m1_gnt);
    end
    tick();
    idle();
  endtask

  task automatic test_alt_reads();
    logic [31:0] d [3];
    logic [31:0] a [3];
    d[0] = 32'hA0A0_0001; d[1] = 32'hB1B1_0002; d[2] = 32'hC2C2_0003;
    a[0] = 32'h10; a[1] = 32'h20; a[2] = 32'h30;
    idle();
    for (int i = 0; i < 4; i++) begin
      bit is0;
      is0 = (i % 2) == 0;
      drive(i < 3 && is0, a[i % 3], 0, 0, i < 3 && !is0, 0, a[i % 3], 0, 0, i > 0 ? d[i - 1] : 32'h0);
      if (i < 3) begin
        checks++;
        if (s_en !== 1 || s_addr !== a[i] || m0_gnt !== is0 || m1_gnt !== !is0) begin
          errors++;
          $display("FAIL alt_grant cyc=%0d gnt=%b%b addr=%h need %h", i, m0_gnt, m1_gnt, s_addr, a[i]);
        end
      end
      if (i > 0) begin
        bit was0;
        was0 = ((i - 1) % 2) == 0;
        checks++;
        if (m0_rvalid !== was0 || m1_rvalid !== !was0 || (was0 ? m0_rdata : m1_rdata) !== d[i - 1]) begin
          errors++;
          $display("FAIL alt_return cyc=%0d rv=%b%b rd0=%h rd1=%h need %h", i, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, d[i - 1]);
        end
      end
      tick();
    end
  endtask

  task automatic test_m1_write();
    idle();
    drive(0, 0, 0, 0, 1, 0, 32'h0000_2003, 4'b0011, 32'h1234_5678, 0);
    checks++;
    if (m1_gnt !== 1 || s_addr !== 32'h0000_2000 || s_be !== 4'b0011 || s_wdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL m1_write gnt=%b addr=%h be=%b wdata=%h need 1 00002000 0011 12345678", m1_gnt, s_addr, s_be, s_wdata);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h5555_AAAA);
    checks++;
    if (m0_rvalid !== 0 || m1_rvalid !== 0) begin
      errors++;
      $display("FAIL write_no_rvalid rv=%b%b need 00", m0_rvalid, m1_rvalid);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    @(negedge clk);
    s_rdata = 32'hFEED_F00D;
    m0_req = 0;
    reset = 1;
    model_reset();
    #1;
    checks++;
    if (m0_rvalid !== 0 || m0_rdata !== 0 || m1_rvalid !== 0) begin
      errors++;
      $display("FAIL reset_mid rv0=%b rd0=%h rv1=%b need 0 0 0", m0_rvalid, m0_rdata, m1_rvalid);
    end
    @(negedge clk);
    reset = 0;
    drive(1, 32'h48, 4'hF, 0, 1, 1, 32'h88, 4'hF, 0, 0);
    checks++;
    if (m0_gnt !== 1 || m1_gnt !== 0 || e_g != 1) begin
      errors++;
      $display("FAIL reset_then_dual gnt=%b%b need 10", m0_gnt, m1_gnt);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (m0_rvalid !== 0) begin
      errors++;
      $display("FAIL reset_no_late rv0=%b need 0", m0_rvalid);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] ea, ew;
      logic [3:0]  eb;
      drive($urandom_range(0, 3) != 0, $urandom, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'd0, $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom,
            ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'd0, $urandom, $urandom);
      ea = e_g == 1 ? {m0_addr[31:2], 2'b00} : e_g == 2 ? {m1_addr[31:2], 2'b00} : 32'd0;
      eb = e_g == 1 ? m0_be : e_g == 2 ? m1_be : 4'd0;
      ew = e_g == 1 ? m0_wdata : e_g == 2 ? m1_wdata : 32'd0;
      checks++;
      if (m0_gnt !== (e_g == 1) || m1_gnt !== (e_g == 2) || s_en !== (e_g != 0) || m0_stall !== (m0_req && e_g != 1)) begin
        errors++;
        $display("FAIL rnd_grant cyc=%0d gnt=%b%b en=%b stall=%b model=%0d", i, m0_gnt, m1_gnt, s_en, m0_stall, e_g);
      end
      checks++;
      if (s_addr !== ea || s_be !== eb || s_wdata !== ew) begin
        errors++;
        $display("FAIL rnd_mux cyc=%0d addr=%h be=%h wd=%h need %h %h %h", i, s_addr, s_be, s_wdata, ea, eb, ew);
      end
      checks++;
      if (m0_rvalid !== e_rv0 || m1_rvalid !== e_rv1 || m0_rdata !== e_rd0 || m1_rdata !== e_rd1) begin
        errors++;
        $display("FAIL rnd_read cyc=%0d rv=%b%b rd0=%h rd1=%h need %b%b %h %h", i, m0_rvalid, m1_rvalid,
                 m0_rdata, m1_rdata, e_rv0, e_rv1, e_rd0, e_rd1);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_m0_read();
    test_starve();
    test_lock();
    test_alt_reads();
    test_m1_write();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
